huffman_decode_param: RTL and testbench

Parametrised canonical-Huffman decoder. It is the successor to the fixed-table `huffman_decoder_v1`. It unpacks MSB-first variable-length codes from a stream of `P_WIDTH`-bit packed words and emits one fixed-width symbol per cycle into a downstream FIFO. Code lengths, first codes and the symbol map are run-time programmable. An end-of-message code ends each message with a `done` pulse and realigns to the next word. Unmatched codes raise a sticky error. Sits between the packed-word source (rdy/pop) and the symbol FIFO (not_full/push).

---
 rtl/huffman_decode_pkg.sv | 17 +
 rtl/huffman_bitbuf.sv | 55 +++++
 rtl/huffman_decode_param.sv | 185 ++++++++++++++++++
 tb/tb_huffman_decode_param.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_decode_pkg.sv
// Shared defaults and FSM state type for the parametrised canonical-Huffman decoder.
package huffman_decode_pkg;

    localparam int unsigned DEF_C_WIDTH    = 4;
    localparam int unsigned DEF_VLC_WIDTH  = 5;
    localparam int unsigned DEF_VLCZ_WIDTH = 3;
    localparam int unsigned DEF_P_WIDTH    = 32;
    localparam int unsigned DEF_EOM_LENGTH = 4;
    localparam logic [DEF_VLC_WIDTH-1:0] DEF_EOM_CODE = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/huffman_bitbuf.sv
// MSB-first 2*P_WIDTH bit buffer: consume L bits from the top, append a word below the valid bits.
module huffman_bitbuf #(
    parameter int unsigned P_WIDTH   = 32,
    parameter int unsigned VLC_WIDTH = 5,
    parameter int unsigned LEN_W     = 3,
    parameter int unsigned FILL_W    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [P_WIDTH-1:0]   i_word,
    input  logic [LEN_W-1:0]     i_consume,
    input  logic                 i_align,
    output logic [VLC_WIDTH-1:0] o_top,
    output logic [FILL_W-1:0]    o_fill
);

    localparam int unsigned BUF_W = 2 * P_WIDTH;
    localparam logic [BUF_W-1:0] ONES = '1;

    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_after;
    logic [FILL_W-1:0] w_loaded;
    logic [FILL_W-1:0] w_final;
    logic [BUF_W-1:0]  w_word;
    logic [BUF_W-1:0]  w_next;

    // Bits below the fill point are kept at zero so a new word can simply be OR-ed in.
    always_comb begin
        w_after  = r_fill - FILL_W'(i_consume);
        w_loaded = w_after + (i_load ? FILL_W'(P_WIDTH) : FILL_W'(0));
        w_final  = i_align ? (w_loaded - (w_loaded % FILL_W'(P_WIDTH))) : w_loaded;
        w_word   = i_load ? ({i_word, {P_WIDTH{1'b0}}} >> w_after) : '0;
        w_next   = ((r_buf << i_consume) | w_word) & ~(ONES >> w_final);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_next;
            r_fill <= w_final;
        end
    end

    assign o_top  = r_buf[BUF_W-1 -: VLC_WIDTH];
    assign o_fill = r_fill;

endmodule

// File: rtl/huffman_decode_param.sv
// Canonical-Huffman decoder with programmable length/symbol tables, EOM handling and sticky error.
module huffman_decode_param
    import huffman_decode_pkg::*;
#(
    parameter int unsigned C_WIDTH    = DEF_C_WIDTH,
    parameter int unsigned VLC_WIDTH  = DEF_VLC_WIDTH,
    parameter int unsigned VLCZ_WIDTH = DEF_VLCZ_WIDTH,
    parameter int unsigned P_WIDTH    = DEF_P_WIDTH,
    parameter logic [VLC_WIDTH-1:0] EOM_CODE = DEF_EOM_CODE,
    parameter int unsigned EOM_LENGTH = DEF_EOM_LENGTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [P_WIDTH-1:0]    idata,
    input  logic                  rdy,
    output logic                  pop,
    input  logic                  not_full,
    output logic [C_WIDTH-1:0]    code,
    output logic                  push,
    output logic                  done,
    output logic                  err,
    input  logic                  cfg_len_we,
    input  logic [VLCZ_WIDTH-1:0] cfg_len_idx,
    input  logic [VLC_WIDTH-1:0]  cfg_first,
    input  logic [C_WIDTH:0]      cfg_count,
    input  logic [C_WIDTH-1:0]    cfg_base,
    input  logic                  cfg_sym_we,
    input  logic [C_WIDTH-1:0]    cfg_sym_addr,
    input  logic [C_WIDTH-1:0]    cfg_sym_data
);

    localparam int unsigned LEN_W  = $clog2(VLC_WIDTH + 1);
    localparam int unsigned FILL_W = $clog2(2 * P_WIDTH + 1);
    localparam int unsigned CMP_W  = (VLC_WIDTH > C_WIDTH + 1) ? VLC_WIDTH : C_WIDTH + 1;
    localparam int unsigned SYM_N  = 2 ** C_WIDTH;
    localparam int unsigned EOM_W  = EOM_LENGTH + 1;

    state_e r_state, w_state_next;

    logic [VLC_WIDTH-1:0] r_first [VLC_WIDTH];
    logic [C_WIDTH:0]     r_count [VLC_WIDTH];
    logic [C_WIDTH-1:0]   r_base  [VLC_WIDTH];
    logic [C_WIDTH-1:0]   r_sym   [SYM_N];

    logic                 r_push, r_done, r_err;
    logic [C_WIDTH-1:0]   r_code;

    logic [VLC_WIDTH-1:0] w_top;
    logic [FILL_W-1:0]    w_fill;
    logic                 w_pop, w_decode, w_eom, w_hit;
    logic [LEN_W-1:0]     w_hit_len;
    logic [C_WIDTH-1:0]   w_hit_idx;
    logic [VLC_WIDTH-1:0] w_v, w_d;
    logic [LEN_W-1:0]     w_consume;
    logic                 w_align, w_clear;
    logic                 w_push_next, w_done_next, w_err_next;
    logic [C_WIDTH-1:0]   w_code_next;

    huffman_bitbuf #(
        .P_WIDTH   (P_WIDTH),
        .VLC_WIDTH (VLC_WIDTH),
        .LEN_W     (LEN_W),
        .FILL_W    (FILL_W)
    ) u_bitbuf (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_load    (w_pop),
        .i_word    (idata),
        .i_consume (w_consume),
        .i_align   (w_align),
        .o_top     (w_top),
        .o_fill    (w_fill)
    );

    assign w_pop    = (r_state == ST_RUN) && rdy && (w_fill <= FILL_W'(P_WIDTH));
    assign w_decode = (r_state == ST_RUN) && not_full && (w_fill >= FILL_W'(VLC_WIDTH));
    assign w_eom    = (w_top[VLC_WIDTH-1 -: EOM_W] == EOM_CODE[VLC_WIDTH-1 -: EOM_W]);

    // Parallel length comparators; scanning longest-first lets the shortest match win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_len = '0;
        w_hit_idx = '0;
        w_v       = '0;
        w_d       = '0;
        for (int l = VLC_WIDTH; l >= 1; l--) begin
            w_v = w_top >> (VLC_WIDTH - l);
            w_d = w_v - r_first[l-1];
            if (CMP_W'(w_d) < CMP_W'(r_count[l-1])) begin
                w_hit     = 1'b1;
                w_hit_len = LEN_W'(l);
                w_hit_idx = C_WIDTH'(r_base[l-1] + C_WIDTH'(w_d));
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_consume    = '0;
        w_align      = 1'b0;
        w_clear      = 1'b0;
        w_push_next  = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = r_err;
        w_code_next  = r_code;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_decode) begin
                    if (w_hit) begin
                        w_consume   = w_hit_len;
                        w_push_next = 1'b1;
                        w_code_next = r_sym[w_hit_idx];
                    end else if (w_eom) begin
                        w_consume    = LEN_W'(EOM_W);
                        w_align      = 1'b1;
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                    w_err_next   = 1'b0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_push  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_next;
            r_push  <= w_push_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_code  <= w_code_next;
        end
    end

    // Tables are frozen while decoding so a running message always sees one consistent code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VLC_WIDTH; i++) begin
                r_first[i] <= '0;
                r_count[i] <= '0;
                r_base[i]  <= '0;
            end
            for (int i = 0; i < SYM_N; i++) begin
                r_sym[i] <= '0;
            end
        end else if (r_state != ST_RUN) begin
            if (cfg_len_we && (32'(cfg_len_idx) < VLC_WIDTH)) begin
                r_first[cfg_len_idx] <= cfg_first;
                r_count[cfg_len_idx] <= cfg_count;
                r_base[cfg_len_idx]  <= cfg_base;
            end
            if (cfg_sym_we) begin
                r_sym[cfg_sym_addr] <= cfg_sym_data;
            end
        end
    end

    assign pop  = w_pop;
    assign push = r_push;
    assign code = r_code;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_huffman_decode_param.sv
// Directed scoreboard bench for huffman_decode_param using the canonical 2/3/4/5-bit test table.
module tb_huffman_decode_param;
    import huffman_decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] idata = '0;
    logic        rdy = 1'b0;
    logic        not_full = 1'b1;
    logic        cfg_len_we = 1'b0;
    logic [2:0]  cfg_len_idx = '0;
    logic [4:0]  cfg_first = '0;
    logic [4:0]  cfg_count = '0;
    logic [3:0]  cfg_base = '0;
    logic        cfg_sym_we = 1'b0;
    logic [3:0]  cfg_sym_addr = '0;
    logic [3:0]  cfg_sym_data = '0;
    logic        pop, push, done, err;
    logic [3:0]  code;

    huffman_decode_param dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .idata        (idata),
        .rdy          (rdy),
        .pop          (pop),
        .not_full     (not_full),
        .code         (code),
        .push         (push),
        .done         (done),
        .err          (err),
        .cfg_len_we   (cfg_len_we),
        .cfg_len_idx  (cfg_len_idx),
        .cfg_first    (cfg_first),
        .cfg_count    (cfg_count),
        .cfg_base     (cfg_base),
        .cfg_sym_we   (cfg_sym_we),
        .cfg_sym_addr (cfg_sym_addr),
        .cfg_sym_data (cfg_sym_data)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        took    = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  obs_sym[$];
    int          obs_cyc[$];
    int          done_cyc[$];
    logic [31:0] words_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        took = pop;
        if (push) begin
            obs_sym.push_back(code);
            obs_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
    end

    // Word source: presents the head of words_q and retires it once popped.
    always @(posedge clk) begin
        #1;
        if (took && words_q.size() > 0) void'(words_q.pop_front());
        rdy   = (words_q.size() > 0);
        idata = rdy ? words_q[0] : 32'h0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_sym.delete();
        obs_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        not_full = 1'b1;
        cfg_len_we = 1'b0;
        cfg_sym_we = 1'b0;
        words_q.delete();
        tick(2);
        reset = 1'b1;
        tick(1);
        clear_obs();
    endtask

    task automatic prog_table(input logic [4:0] cnt4);
        logic [4:0] f[4];
        logic [4:0] c[4];
        logic [3:0] b[4];
        f = '{5'd0, 5'd4, 5'd12, 5'd28};
        c = '{5'd2, 5'd2, cnt4, 5'd3};
        b = '{4'd0, 4'd2, 4'd4, 4'd6};
        for (int l = 0; l < 4; l++) begin
            cfg_len_we  = 1'b1;
            cfg_len_idx = 3'(l + 1);
            cfg_first   = f[l];
            cfg_count   = c[l];
            cfg_base    = b[l];
            tick(1);
        end
        cfg_len_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cfg_sym_we   = 1'b1;
            cfg_sym_addr = 4'(i);
            cfg_sym_data = 4'(i);
            tick(1);
        end
        cfg_sym_we = 1'b0;
    endtask

    // Drives the basic message with optional backpressure window or RUN-time config write.
    task automatic run_message(input bit bp, input bit cfgw, output int k, output logic pop1);
        clear_obs();
        words_q.push_back(32'h1973E000);
        for (int i = 0; i < 5; i++) exp_q.push_back(4'(i));
        tick(2);
        start = 1'b1;
        k = cyc;
        tick(1);
        start = 1'b0;
        pop1 = pop;
        for (int j = 0; j < 30; j++) begin
            if (bp && cyc == k + 4) not_full = 1'b0;
            if (bp && cyc == k + 14) not_full = 1'b1;
            if (cfgw && cyc == k + 3) begin
                cfg_len_we = 1'b1; cfg_len_idx = 3'd1;
                cfg_first = 5'd0; cfg_count = 5'd0; cfg_base = 4'd0;
            end else begin
                cfg_len_we = 1'b0;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(1);
        n_tests += 7;
        if (pop !== 1'b0)  begin n_fail++; $display("FAIL reset_pop: got %b expected 0", pop); end
        if (push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b expected 0", push); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        if (code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", code); end
        if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dut.r_state); end
        if (dut.u_bitbuf.r_fill !== 7'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", dut.u_bitbuf.r_fill); end
        reset = 1'b1;
        tick(1);
        clear_obs();
    endtask

    task automatic test_basic();
        int k;
        logic pop1;
        int i;
        run_message(1'b0, 1'b0, k, pop1);
        n_tests++;
        if (pop1 !== 1'b1) begin n_fail++; $display("FAIL basic_pop_latency: got %b expected 1", pop1); end
        n_tests++;
        if (obs_sym.size() != 5) begin n_fail++; $display("FAIL basic_push_count: got %0d expected 5", obs_sym.size()); end
        i = 0;
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (obs_sym.size() == 0) begin
                n_fail++; $display("FAIL basic_sym[%0d]: got none expected %0d", i, e);
            end else begin
                logic [3:0] o;
                int oc;
                o = obs_sym.pop_front();
                oc = obs_cyc.pop_front();
                if (o !== e || oc != k + 3 + i) begin
                    n_fail++; $display("FAIL basic_sym[%0d]: got %0d@%0d expected %0d@%0d", i, o, oc, e, k + 3 + i);
                end
            end
            i++;
        end
        n_tests += 3;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 8) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses first@%0d expected 1@%0d", done_cyc.size(),
                               (done_cyc.size() > 0) ? done_cyc[0] : -1, k + 8);
        end
        if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL basic_state: got %0d expected IDLE", dut.r_state); end
        if (dut.u_bitbuf.r_fill !== 7'd0) begin n_fail++; $display("FAIL basic_fill: got %0d expected 0", dut.u_bitbuf.r_fill); end
    endtask

    task automatic test_straddle();
        int k;
        clear_obs();
        words_q.push_back(32'hB6DB6DB6);
        words_q.push_back(32'hDB6DB6DB);
        for (int i = 0; i < 20; i++) exp_q.push_back(4'd3);
        tick(2);
        start = 1'b1;
        k = cyc;
        tick(1);
        start = 1'b0;
        tick(30);
        n_tests++;
        if (obs_sym.size() != 20) begin n_fail++; $display("FAIL straddle_count: got %0d expected 20", obs_sym.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_sym.size() > 0; i++) begin
            logic [3:0] e, o;
            int oc;
            e = exp_q.pop_front();
            o = obs_sym.pop_front();
            oc = obs_cyc.pop_front();
            n_tests++;
            if (o !== e || oc != k + 3 + i) begin
                n_fail++; $display("FAIL straddle_sym[%0d]: got %0d@%0d expected %0d@%0d", i, o, oc, e, k + 3 + i);
            end
        end
        n_tests += 2;
        if (dut.r_state !== ST_RUN) begin n_fail++; $display("FAIL straddle_state: got %0d expected RUN", dut.r_state); end
        if (dut.u_bitbuf.r_fill !== 7'd4) begin n_fail++; $display("FAIL straddle_fill: got %0d expected 4", dut.u_bitbuf.r_fill); end
        do_reset();
        prog_table(5'd2);
    endtask

    task automatic test_backpressure();
        int k;
        int in_window;
        logic pop1;
        run_message(1'b1, 1'b0, k, pop1);
        in_window = 0;
        foreach (obs_cyc[i]) if (obs_cyc[i] >= k + 5 && obs_cyc[i] <= k + 14) in_window++;
        n_tests += 2;
        if (in_window != 0) begin n_fail++; $display("FAIL bp_stall: got %0d pushes expected 0", in_window); end
        if (done_cyc.size() != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cyc.size()); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (obs_sym.size() == 0) begin
                n_fail++; $display("FAIL bp_sym[%0d]: got none expected %0d", i, e);
            end else begin
                logic [3:0] o;
                o = obs_sym.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL bp_sym[%0d]: got %0d expected %0d", i, o, e); end
            end
        end
        n_tests++;
        if (obs_sym.size() != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra pushes expected 0", obs_sym.size()); end
    endtask

    task automatic test_cfg_in_run();
        int k;
        logic pop1;
        run_message(1'b0, 1'b1, k, pop1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (obs_sym.size() == 0) begin
                n_fail++; $display("FAIL cfgrun_sym[%0d]: got none expected %0d", i, e);
            end else begin
                logic [3:0] o;
                o = obs_sym.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL cfgrun_sym[%0d]: got %0d expected %0d", i, o, e); end
            end
        end
        n_tests++;
        if (dut.r_count[1] !== 5'd2) begin n_fail++; $display("FAIL cfgrun_table: got count %0d expected 2", dut.r_count[1]); end
    endtask

    task automatic test_unmatched();
        clear_obs();
        prog_table(5'd1);
        words_q.push_back(32'hD0000000);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        n_tests += 4;
        if (err !== 1'b1) begin n_fail++; $display("FAIL unmatched_err: got %b expected 1", err); end
        if (obs_sym.size() != 0) begin n_fail++; $display("FAIL unmatched_push: got %0d expected 0", obs_sym.size()); end
        if (dut.r_state !== ST_ERR) begin n_fail++; $display("FAIL unmatched_state: got %0d expected ERR", dut.r_state); end
        if (dut.u_bitbuf.r_fill !== 7'd32) begin n_fail++; $display("FAIL unmatched_fill: got %0d expected 32", dut.u_bitbuf.r_fill); end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_tests += 3;
        if (err !== 1'b0) begin n_fail++; $display("FAIL restart_err: got %b expected 0", err); end
        if (dut.u_bitbuf.r_fill !== 7'd0) begin n_fail++; $display("FAIL restart_fill: got %0d expected 0", dut.u_bitbuf.r_fill); end
        if (dut.r_state !== ST_RUN) begin n_fail++; $display("FAIL restart_state: got %0d expected RUN", dut.r_state); end
        do_reset();
        prog_table(5'd2);
    endtask

    task automatic test_reset_mid();
        clear_obs();
        words_q.push_back(32'hB6DB6DB6);
        words_q.push_back(32'hDB6DB6DB);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        #2;
        reset = 1'b0;
        words_q.delete();
        #1;
        n_tests += 5;
        if (push !== 1'b0) begin n_fail++; $display("FAIL midreset_push: got %b expected 0", push); end
        if (pop !== 1'b0)  begin n_fail++; $display("FAIL midreset_pop: got %b expected 0", pop); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        if (err !== 1'b0)  begin n_fail++; $display("FAIL midreset_err: got %b expected 0", err); end
        if (dut.r_count[2] !== 5'd0) begin n_fail++; $display("FAIL midreset_table: got %0d expected 0", dut.r_count[2]); end
        tick(2);
        reset = 1'b1;
        tick(1);
        clear_obs();
        words_q.push_back(32'h1973E000);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        n_tests += 2;
        if (obs_sym.size() != 0) begin n_fail++; $display("FAIL noprog_push: got %0d expected 0", obs_sym.size()); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL noprog_err: got %b expected 1", err); end
        do_reset();
        prog_table(5'd2);
        words_q.push_back(32'h1973E000);
        for (int i = 0; i < 5; i++) exp_q.push_back(4'(i));
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (obs_sym.size() == 0) begin
                n_fail++; $display("FAIL resume_sym[%0d]: got none expected %0d", i, e);
            end else begin
                logic [3:0] o;
                o = obs_sym.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL resume_sym[%0d]: got %0d expected %0d", i, o, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        prog_table(5'd2);
        test_basic();
        test_straddle();
        test_backpressure();
        test_cfg_in_run();
        test_unmatched();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
